// File: rtl/gpu_pixel_scanout.sv
// gpu_pixel_scanout
//   Pixel back end behind the VGA timing generator. It turns the visible
//   row/col into a framebuffer address, waits for the VRAM read data, maps the
//   8-bit index through a 256x12 palette and registers the result onto the
//   colour pins. displayEnable and the syncs ride a delay line of the same
//   depth, so colour and sync reach the DAC aligned.
//   Total latency from input to output: L = 2 + MEM_LATENCY clocks.
//
// Parameters
//   FB_WIDTH     framebuffer pixels per line
//   SCALE_SHIFT  screen-to-framebuffer shift (1 = 2x2 pixel doubling)
//   MEM_LATENCY  fixed VRAM read latency, 1..4
//
// Ports
//   clockVGA, reset          pixel clock, async active-high reset
//   displayEnable, row, col  visible-area flag and position from the timing gen
//   hsync_n, vsync_n         active-low syncs from the timing gen
//   vramAddr / vramData      framebuffer read address / palette index returned
//   palWrite/palAddr/palData palette write port, {R,G,B} 4 bits each
//   red, green, blue         4-bit colour outputs
//   hsyncOut_n, vsyncOut_n   syncs delayed to line up with the colour
//   frameStart               1-cycle pulse on output pixel (0,0)
//
// Optional feature: define SCANOUT_TESTPATTERN_EN to add the testPattern input,
// which replaces the palette colour with a row/col derived pattern.

module gpu_pixel_scanout #(
  parameter int FB_WIDTH    = 320,
  parameter int SCALE_SHIFT = 1,
  parameter int MEM_LATENCY = 1
) (
  input  logic        clockVGA,
  input  logic        reset,
  input  logic        displayEnable,
  input  logic [9:0]  row,
  input  logic [9:0]  col,
  input  logic        hsync_n,
  input  logic        vsync_n,
  output logic [16:0] vramAddr,
  input  logic [7:0]  vramData,
  input  logic        palWrite,
  input  logic [7:0]  palAddr,
  input  logic [11:0] palData,
`ifdef SCANOUT_TESTPATTERN_EN
  input  logic        testPattern,
`endif
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        hsyncOut_n,
  output logic        vsyncOut_n,
  output logic        frameStart
);

  localparam int          L  = 2 + MEM_LATENCY;
  // Pixel attributes only need L-1 stages: the colour register is the last one.
  localparam int unsigned DL = L - 1;

  typedef enum logic {
    WAIT_VSYNC = 1'b0,
    LOCKED     = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic            vs_prev_q, vs_prev_d;
  logic [16:0]     vramAddr_q, vramAddr_d;
  logic [DL-1:0]   de_q, de_d;
  logic [L-1:0]    hs_q, hs_d;
  logic [L-1:0]    vs_q, vs_d;
  logic [11:0]     rgb_q, rgb_d;
  logic            fs_q, fs_d;
  logic [11:0]     pal_q [256];

`ifdef SCANOUT_TESTPATTERN_EN
  logic [9:0]      row_dl_q [DL];
  logic [9:0]      row_dl_d [DL];
  logic [9:0]      col_dl_q [DL];
  logic [9:0]      col_dl_d [DL];
  logic [DL-1:0]   tp_q, tp_d;
`else
  logic [DL-1:0]   zf_q, zf_d;
`endif

  always_comb begin
    state_d = state_q;
    if (state_q == WAIT_VSYNC && vs_prev_q && !vsync_n) begin
      state_d = LOCKED;
    end
    vs_prev_d = vsync_n;

    // 17-bit arithmetic: anything above bit 16 is dropped.
    vramAddr_d = 17'(row >> SCALE_SHIFT) * 17'(FB_WIDTH) + 17'(col >> SCALE_SHIFT);

    de_d = {de_q[DL-2:0], displayEnable};
    hs_d = {hs_q[L-2:0], hsync_n};
    vs_d = {vs_q[L-2:0], vsync_n};

`ifdef SCANOUT_TESTPATTERN_EN
    row_dl_d[0] = row;
    col_dl_d[0] = col;
    for (int unsigned i = 1; i < DL; i++) begin
      row_dl_d[i] = row_dl_q[i-1];
      col_dl_d[i] = col_dl_q[i-1];
    end
    // testPattern is delayed with its pixel so the switch lands on a pixel boundary.
    tp_d = {tp_q[DL-2:0], testPattern};
`else
    zf_d = {zf_q[DL-2:0], (row == 10'd0) && (col == 10'd0)};
`endif

    rgb_d = '0;
    fs_d  = 1'b0;
    if (de_q[DL-1] && state_q == LOCKED) begin
      rgb_d = pal_q[vramData];
`ifdef SCANOUT_TESTPATTERN_EN
      if (tp_q[DL-1]) begin
        rgb_d = {col_dl_q[DL-1][7:4], row_dl_q[DL-1][7:4],
                 col_dl_q[DL-1][3:0] ^ row_dl_q[DL-1][3:0]};
      end
      fs_d = (row_dl_q[DL-1] == 10'd0) && (col_dl_q[DL-1] == 10'd0);
`else
      fs_d = zf_q[DL-1];
`endif
    end
  end

  always_ff @(posedge clockVGA or posedge reset) begin
    if (reset) begin
      state_q    <= WAIT_VSYNC;
      vs_prev_q  <= 1'b1;
      vramAddr_q <= '0;
      de_q       <= '0;
      hs_q       <= '1;
      vs_q       <= '1;
      rgb_q      <= '0;
      fs_q       <= 1'b0;
`ifdef SCANOUT_TESTPATTERN_EN
      for (int unsigned i = 0; i < DL; i++) begin
        row_dl_q[i] <= '0;
        col_dl_q[i] <= '0;
      end
      tp_q <= '0;
`else
      zf_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      vs_prev_q  <= vs_prev_d;
      vramAddr_q <= vramAddr_d;
      de_q       <= de_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      rgb_q      <= rgb_d;
      fs_q       <= fs_d;
`ifdef SCANOUT_TESTPATTERN_EN
      for (int unsigned i = 0; i < DL; i++) begin
        row_dl_q[i] <= row_dl_d[i];
        col_dl_q[i] <= col_dl_d[i];
      end
      tp_q <= tp_d;
`else
      zf_q <= zf_d;
`endif
    end
  end

  // Palette is not reset; a same-edge read sees the old entry.
  always_ff @(posedge clockVGA) begin
    if (palWrite) begin
      pal_q[palAddr] <= palData;
    end
  end

  assign vramAddr   = vramAddr_q;
  assign red        = rgb_q[11:8];
  assign green      = rgb_q[7:4];
  assign blue       = rgb_q[3:0];
  assign hsyncOut_n = hs_q[L-1];
  assign vsyncOut_n = vs_q[L-1];
  assign frameStart = fs_q;

endmodule
